// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one column at a time, debounces the
//   key seen in the active column and publishes its hex code.
//
//   Ports
//     clk        system clock
//     rst        asynchronous reset, active-high
//     row[3:0]   keypad rows, active-low, asynchronous to clk
//     col[3:0]   column drive, active-low, exactly one column low
//     keypadBuf  last accepted key code, held until the next accepted press
//     key_valid  one-cycle strobe in the cycle keypadBuf takes a new press
//     key_down   high from an accepted press until its release is debounced
module keypad_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] keypadBuf,
  output logic       key_valid,
  output logic       key_down
);

  localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W  = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
  // The counter never stores the threshold itself: the sample that would
  // reach it causes the transition instead, so DEBOUNCE_CNT-1 is the top.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
  // With a threshold of one, the very first sample already decides.
  localparam bit ACCEPT_FIRST = (DEBOUNCE_CNT <= 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t            state, state_next;
  logic [3:0]        row_meta, row_sync;
  logic [3:0]        rs;
  logic [TICK_W-1:0] tick;
  logic [1:0]        col_idx;
  logic [3:0]        cand;
  logic [CNT_W-1:0]  cnt;
  logic              slot_end, any_key, same_key;
  logic [1:0]        hit_row;
  logic [3:0]        code;
  logic              advance, load_cand, cnt_one, cnt_inc, accept, release_done;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return 4'h1;
      4'h1: return 4'h2;
      4'h2: return 4'h3;
      4'h3: return 4'hA;
      4'h4: return 4'h4;
      4'h5: return 4'h5;
      4'h6: return 4'h6;
      4'h7: return 4'hB;
      4'h8: return 4'h7;
      4'h9: return 4'h8;
      4'hA: return 4'h9;
      4'hB: return 4'hC;
      4'hC: return 4'hE;
      4'hD: return 4'h0;
      4'hE: return 4'hF;
      default: return 4'hD;
    endcase
  endfunction

  // Rows idle high, so the synchronizer resets to "nothing pressed".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  assign rs       = ~row_sync;
  assign slot_end = (tick == TICK_LAST);
  assign any_key  = |rs;
  assign col      = ~(4'b0001 << col_idx);

  // Lowest pressed row index wins when several rows are active.
  always_comb begin
    hit_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (rs[r]) hit_row = 2'(r);
    end
    code     = key_code(hit_row, col_idx);
    same_key = (code == cand);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SCAN;
    else     state <= state_next;
  end

  // Next-state logic; nothing moves except at slot end.
  always_comb begin
    state_next = state;
    if (slot_end) begin
      case (state)
        SCAN:
          if (any_key) state_next = ACCEPT_FIRST ? HELD : DEBOUNCE;
        DEBOUNCE:
          if (!any_key)                         state_next = SCAN;
          else if (same_key && cnt == CNT_LAST) state_next = HELD;
        HELD:
          if (!any_key) state_next = ACCEPT_FIRST ? SCAN : RELEASE;
        RELEASE:
          if (any_key)              state_next = HELD;
          else if (cnt == CNT_LAST) state_next = SCAN;
        default: state_next = SCAN;
      endcase
    end
  end

  // Datapath controls derived from the state and the slot-end sample.
  always_comb begin
    advance      = 1'b0;
    load_cand    = 1'b0;
    cnt_one      = 1'b0;
    cnt_inc      = 1'b0;
    accept       = 1'b0;
    release_done = 1'b0;
    if (slot_end) begin
      case (state)
        SCAN:
          if (!any_key) advance = 1'b1;
          else begin
            load_cand = 1'b1;
            cnt_one   = 1'b1;
            accept    = ACCEPT_FIRST;
          end
        DEBOUNCE:
          if (!any_key) advance = 1'b1;
          else if (!same_key) begin
            load_cand = 1'b1;
            cnt_one   = 1'b1;
          end else if (cnt == CNT_LAST) accept  = 1'b1;
          else                          cnt_inc = 1'b1;
        HELD:
          if (!any_key) begin
            cnt_one      = 1'b1;
            release_done = ACCEPT_FIRST;
            advance      = ACCEPT_FIRST;
          end
        RELEASE:
          if (!any_key) begin
            if (cnt == CNT_LAST) begin
              release_done = 1'b1;
              advance      = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick      <= '0;
      col_idx   <= 2'd0;
      cand      <= 4'h0;
      cnt       <= '0;
      keypadBuf <= 4'h0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      tick      <= slot_end ? '0 : tick + TICK_W'(1);
      key_valid <= accept;
      if (advance)   col_idx <= col_idx + 2'd1;
      if (load_cand) cand    <= code;
      if (cnt_one)      cnt <= CNT_W'(1);
      else if (cnt_inc) cnt <= cnt + CNT_W'(1);
      // An accepted code always equals the current sample.
      if (accept) begin
        keypadBuf <= code;
        key_down  <= 1'b1;
      end else if (release_done) begin
        key_down  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Drives keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=3) through a keypad model
//   whose rows follow the driven column, and checks it against a slot-level
//   reference model of the scan / debounce rules.
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int P_IDLE    = 0;
  localparam int P_CONFIRM = 1;
  localparam int P_DOWN    = 2;
  localparam int P_LETGO   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] keypadBuf;
  logic       key_valid;
  logic       key_down;

  bit [15:0]  pressed;          // index r*4+c
  bit         glitch_en;
  logic [3:0] glitch_row;

  int checks   = 0;
  int failures = 0;

  // Key code for row r, column c at index r*4+c.
  int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  // Reference model state
  int         m_tick, m_col, m_phase, m_cand, m_cnt;
  logic [3:0] m_buf;
  bit         m_valid, m_down;
  logic [3:0] m_meta, m_sync;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .keypadBuf(keypadBuf), .key_valid(key_valid), .key_down(key_down)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its row low when its column is low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
    if (glitch_en) row = glitch_row;
  end

  function automatic void model_reset();
    m_tick = 0; m_col = 0; m_phase = P_IDLE; m_cand = 0; m_cnt = 0;
    m_buf = 4'h0; m_valid = 1'b0; m_down = 1'b0;
    m_meta = 4'hF; m_sync = 4'hF;
  endfunction

  function automatic void model_edge(input logic [3:0] rae);
    int pr;
    int code;
    m_valid = 1'b0;
    if (m_tick == SCAN_DIV - 1) begin
      pr = -1;
      for (int r = 3; r >= 0; r--) if (!m_sync[r]) pr = r;
      code = (pr < 0) ? -1 : keymap[pr*4 + m_col];
      case (m_phase)
        P_IDLE: begin
          if (code < 0) m_col = (m_col + 1) % 4;
          else begin m_cand = code; m_cnt = 1; m_phase = P_CONFIRM; end
        end
        P_CONFIRM: begin
          if (code < 0) begin m_phase = P_IDLE; m_col = (m_col + 1) % 4; end
          else if (code != m_cand) begin m_cand = code; m_cnt = 1; end
          else m_cnt++;
        end
        P_DOWN: begin
          if (code < 0) begin m_cnt = 1; m_phase = P_LETGO; end
        end
        default: begin
          if (code < 0) m_cnt++;
          else m_phase = P_DOWN;
        end
      endcase
      if (m_phase == P_CONFIRM && m_cnt >= DEBOUNCE_CNT) begin
        m_buf = 4'(m_cand); m_valid = 1'b1; m_down = 1'b1; m_phase = P_DOWN;
      end
      if (m_phase == P_LETGO && m_cnt >= DEBOUNCE_CNT) begin
        m_down = 1'b0; m_phase = P_IDLE; m_col = (m_col + 1) % 4;
      end
    end
    m_tick = (m_tick + 1) % SCAN_DIV;
    m_sync = m_meta;
    m_meta = rae;
  endfunction

  function automatic logic [9:0] model_outputs();
    logic [3:0] ec;
    ec = ~(4'b0001 << m_col);
    return {ec, m_buf, m_valid, m_down};
  endfunction

  // Advance exactly one clock; rows are sampled just before the edge.
  task automatic step();
    logic [3:0] rae;
    #1 rae = row;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(rae);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] ec;
    pressed = '0; glitch_en = 1'b0; glitch_row = 4'hF;
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({col, keypadBuf, key_valid, key_down} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values: got %b want %b", {col, keypadBuf, key_valid, key_down}, {4'b1110, 4'h0, 1'b0, 1'b0});
    end
    repeat (2) step();
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      ec = ~(4'b0001 << ((k / 4) % 4));
      checks++;
      if (col !== ec) begin
        failures++;
        $display("FAIL reset_scan_col: cycle %0d got %b want %b", k, col, ec);
      end
      checks++;
      if ({col, keypadBuf, key_valid, key_down} !== model_outputs()) begin
        failures++;
        $display("FAIL reset_scan_model: got %b want %b", {col, keypadBuf, key_valid, key_down}, model_outputs());
      end
    end
  endtask

  task automatic test_clean_press();
    int np;
    np = 0;
    pressed = 16'(1 << (1*4 + 2));
    repeat (40) begin
      step();
      np += int'(key_valid);
      checks++;
      if ({col, keypadBuf, key_valid, key_down} !== model_outputs()) begin
        failures++;
        $display("FAIL clean_press_cycle: got %b want %b", {col, keypadBuf, key_valid, key_down}, model_outputs());
      end
    end
    checks++;
    if (np != 1 || keypadBuf !== 4'h6 || key_down !== 1'b1) begin
      failures++;
      $display("FAIL clean_press_accept: got pulses=%0d buf=%h down=%b want pulses=1 buf=6 down=1", np, keypadBuf, key_down);
    end
    pressed = '0;
    repeat (30) begin
      step();
      np += int'(key_valid);
      checks++;
      if ({col, keypadBuf, key_valid, key_down} !== model_outputs()) begin
        failures++;
        $display("FAIL clean_release_cycle: got %b want %b", {col, keypadBuf, key_valid, key_down}, model_outputs());
      end
    end
    checks++;
    if (np != 1 || keypadBuf !== 4'h6 || key_down !== 1'b0) begin
      failures++;
      $display("FAIL clean_release: got pulses=%0d buf=%h down=%b want pulses=1 buf=6 down=0", np, keypadBuf, key_down);
    end
  endtask

  task automatic test_bounce();
    int np;
    np = 0;
    for (int s = 0; s < 5; s++) begin
      pressed = (s % 2 == 0) ? 16'h0001 : 16'h0000;
      repeat (SCAN_DIV) begin
        step();
        np += int'(key_valid);
        checks++;
        if ({col, keypadBuf, key_valid, key_down} !== model_outputs()) begin
          failures++;
          $display("FAIL bounce_cycle: got %b want %b", {col, keypadBuf, key_valid, key_down}, model_outputs());
        end
      end
    end
    checks++;
    if (np != 0) begin
      failures++;
      $display("FAIL bounce_no_strobe: got pulses=%0d want 0", np);
    end
    pressed = 16'h0001;
    repeat (40) begin
      step();
      np += int'(key_valid);
      checks++;
      if ({col, keypadBuf, key_valid, key_down} !== model_outputs()) begin
        failures++;
        $display("FAIL bounce_stable_cycle: got %b want %b", {col, keypadBuf, key_valid, key_down}, model_outputs());
      end
    end
    checks++;
    if (np != 1 || keypadBuf !== 4'h1) begin
      failures++;
      $display("FAIL bounce_accept: got pulses=%0d buf=%h want pulses=1 buf=1", np, keypadBuf);
    end
    pressed = '0;
    repeat (30) step();
  endtask

  task automatic test_two_keys();
    int np;
    np = 0;
    pressed = 16'(1 << (1*4 + 3)) | 16'(1 << (2*4 + 3));
    repeat (40) begin
      step();
      np += int'(key_valid);
      checks++;
      if ({col, keypadBuf, key_valid, key_down} !== model_outputs()) begin
        failures++;
        $display("FAIL two_keys_cycle: got %b want %b", {col, keypadBuf, key_valid, key_down}, model_outputs());
      end
    end
    checks++;
    if (np != 1 || keypadBuf !== 4'hB) begin
      failures++;
      $display("FAIL two_keys_priority: got pulses=%0d buf=%h want pulses=1 buf=b", np, keypadBuf);
    end
    pressed |= 16'(1 << (3*4 + 0));
    repeat (20) begin
      step();
      np += int'(key_valid);
    end
    checks++;
    if (np != 1 || keypadBuf !== 4'hB || key_down !== 1'b1) begin
      failures++;
      $display("FAIL other_column_ignored: got pulses=%0d buf=%h down=%b want pulses=1 buf=b down=1", np, keypadBuf, key_down);
    end
    pressed = '0;
    repeat (30) step();
  endtask

  task automatic test_release_glitch();
    int np;
    int k;
    int drops;
    np = 0; drops = 0;
    k = int'($urandom_range(0, 15));
    pressed = 16'(1 << k);
    repeat (40) begin
      step();
      np += int'(key_valid);
    end
    checks++;
    if (np != 1 || keypadBuf !== 4'(keymap[k]) || key_down !== 1'b1) begin
      failures++;
      $display("FAIL glitch_key_accept: key %0d got pulses=%0d buf=%h down=%b want pulses=1 buf=%h down=1", k, np, keypadBuf, key_down, 4'(keymap[k]));
    end
    pressed = '0;
    repeat (SCAN_DIV) begin
      step();
      np += int'(key_valid);
      if (key_down !== 1'b1) drops++;
    end
    pressed = 16'(1 << k);
    repeat (20) begin
      step();
      np += int'(key_valid);
      if (key_down !== 1'b1) drops++;
      checks++;
      if ({col, keypadBuf, key_valid, key_down} !== model_outputs()) begin
        failures++;
        $display("FAIL release_glitch_cycle: got %b want %b", {col, keypadBuf, key_valid, key_down}, model_outputs());
      end
    end
    checks++;
    if (np != 1 || drops != 0) begin
      failures++;
      $display("FAIL release_glitch: got pulses=%0d down_drops=%0d want pulses=1 down_drops=0", np, drops);
    end
    pressed = '0;
    repeat (30) step();
  endtask

  task automatic test_row_glitch();
    int np;
    int t;
    int sel;
    logic [3:0] c0;
    logic [3:0] ec;
    np = 0;
    for (int it = 0; it < 3; it++) begin
      sel = int'($urandom_range(0, 2));
      t = (sel == 0) ? 0 : sel + 1;     // tick 0, 2 or 3
      for (int i = 0; i < 8 && m_tick != t; i++) step();
      sel = int'($urandom_range(0, 3));
      glitch_row = ~(4'b0001 << sel);
      glitch_en = 1'b1;
      step();
      np += int'(key_valid);
      glitch_en = 1'b0;
      repeat (8) begin
        step();
        np += int'(key_valid);
        checks++;
        if ({col, keypadBuf, key_valid, key_down} !== model_outputs()) begin
          failures++;
          $display("FAIL row_glitch_cycle: got %b want %b", {col, keypadBuf, key_valid, key_down}, model_outputs());
        end
      end
      c0 = col;
      ec = {c0[2:0], c0[3]};
      repeat (SCAN_DIV) step();
      checks++;
      if (col !== ec || key_down !== 1'b0) begin
        failures++;
        $display("FAIL row_glitch_still_scanning: got col=%b down=%b want col=%b down=0", col, key_down, ec);
      end
    end
    checks++;
    if (np != 0) begin
      failures++;
      $display("FAIL row_glitch_no_strobe: got pulses=%0d want 0", np);
    end
  endtask

  task automatic test_random();
    int hold;
    for (int it = 0; it < 25; it++) begin
      pressed = 16'(1 << $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) pressed |= 16'(1 << $urandom_range(0, 15));
      hold = int'($urandom_range(1, 40));
      for (int ph = 0; ph < 2; ph++) begin
        repeat (hold) begin
          step();
          checks++;
          if ({col, keypadBuf, key_valid, key_down} !== model_outputs()) begin
            failures++;
            $display("FAIL random_cycle: iter %0d got %b want %b", it, {col, keypadBuf, key_valid, key_down}, model_outputs());
          end
        end
        pressed = '0;
        hold = int'($urandom_range(1, 30));
      end
    end
    repeat (30) step();
  endtask

  task automatic test_reset_midop();
    int np;
    bit ok;
    np = 0; ok = 1'b0;
    pressed = 16'(1 << (2*4 + 1));
    for (int i = 0; i < 60 && !ok; i++) begin
      step();
      if (key_down === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL midop_wait_held: got key_down=%b want 1 within 60 cycles", key_down);
    end
    step();
    #3 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({col, keypadBuf, key_valid, key_down} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL midop_async_reset: got %b want %b", {col, keypadBuf, key_valid, key_down}, {4'b1110, 4'h0, 1'b0, 1'b0});
    end
    repeat (2) step();
    rst = 1'b0;
    repeat (60) begin
      step();
      np += int'(key_valid);
      checks++;
      if ({col, keypadBuf, key_valid, key_down} !== model_outputs()) begin
        failures++;
        $display("FAIL midop_redetect_cycle: got %b want %b", {col, keypadBuf, key_valid, key_down}, model_outputs());
      end
    end
    checks++;
    if (np != 1 || keypadBuf !== 4'h8) begin
      failures++;
      $display("FAIL midop_redetect: got pulses=%0d buf=%h want pulses=1 buf=8", np, keypadBuf);
    end
    pressed = '0;
    repeat (30) step();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_two_keys();
    test_release_glitch();
    test_row_glitch();
    test_random();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
